// File: rtl/telemetry_framer.sv
// Telemetry framer: snapshots NUM_CH status channels and streams
// SYNC, LEN, SEQ, payload, CHK bytes to a UART transmitter.
`timescale 1ns/1ps
module telemetry_framer #(
    parameter int         NUM_CH        = 4,
    parameter int         CH_WIDTH      = 8,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter logic [7:0] CMD_BYTE      = 8'h82,
    parameter int         PERIOD_CYCLES = 5_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic                       mode,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_byte,
    output logic                       rx_ready,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_byte,
    output logic                       busy,
    output logic [7:0]                 seq,
    output logic [7:0]                 overrun_count
);

    localparam int BPC     = (CH_WIDTH + 7) / 8;
    localparam int PAY_LEN = NUM_CH * BPC;
    localparam int IW      = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;
    localparam int TW      = $clog2(PERIOD_CYCLES);

    localparam logic [7:0]    LEN_BYTE = 8'(PAY_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(PAY_LEN - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(PERIOD_CYCLES - 1);

    if (PAY_LEN > 255) begin : g_len_chk
        $error("telemetry_framer: NUM_CH*BPC must not exceed 255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_SEQ,
        S_PAY,
        S_CHK
    } state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    ovr_q, ovr_d;
    logic [7:0]    chk_q, chk_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rx_ready_q;
    logic [7:0]    snap_q   [PAY_LEN];
    logic [7:0]    snap_d   [PAY_LEN];
    logic [7:0]    snap_new [PAY_LEN];

    logic [BPC*8-1:0] pad;
    logic             cmd_hit;
    logic             timer_wrap;
    logic             trig;
    logic             fire;
    logic             start;
    logic [7:0]       pay_byte;

    assign cmd_hit    = mode && rx_valid && rx_ready_q && (rx_byte == CMD_BYTE);
    assign timer_wrap = !mode && (timer_q == T_LAST);
    assign trig       = cmd_hit || timer_wrap;

    assign tx_valid      = (state_q != S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign fire          = tx_valid && tx_ready;
    assign rx_ready      = rx_ready_q;
    assign seq           = seq_q;
    assign overrun_count = ovr_q;
    assign pay_byte      = snap_q[idx_q];

    // Each channel is zero-padded to BPC bytes, low byte first.
    always_comb begin
        pad = '0;
        for (int b = 0; b < PAY_LEN; b++) snap_new[b] = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            pad = '0;
            pad[CH_WIDTH-1:0] = ch_data[c*CH_WIDTH +: CH_WIDTH];
            for (int k = 0; k < BPC; k++) snap_new[c*BPC+k] = pad[k*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        seq_d     = seq_q;
        ovr_d     = ovr_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        start     = 1'b0;

        if (mode)            timer_d = '0;
        else if (timer_wrap) timer_d = '0;
        else                 timer_d = timer_q + 1'b1;

        if (state_q != S_IDLE && trig) begin
            if (!pending_q)          pending_d = 1'b1;
            else if (ovr_q != 8'hFF) ovr_d     = ovr_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (trig || pending_q) begin
                    start     = 1'b1;
                    pending_d = trig && pending_q;
                end
            end
            S_SYNC: if (fire) state_d = S_LEN;
            S_LEN: begin
                if (fire) begin
                    chk_d   = LEN_BYTE;
                    state_d = S_SEQ;
                end
            end
            S_SEQ: begin
                if (fire) begin
                    chk_d   = chk_q ^ seq_q;
                    idx_d   = '0;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                if (fire) begin
                    chk_d = chk_q ^ pay_byte;
                    if (idx_q == LAST_IDX) state_d = S_CHK;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            S_CHK: begin
                if (fire) begin
                    seq_d = seq_q + 8'd1;
                    // A queued trigger chains straight into the next SYNC.
                    if (pending_q) begin
                        start     = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_SYNC;
            snap_d  = snap_new;
        end
    end

    always_comb begin
        unique case (state_q)
            S_SYNC:  tx_byte = SYNC_BYTE;
            S_LEN:   tx_byte = LEN_BYTE;
            S_SEQ:   tx_byte = seq_q;
            S_PAY:   tx_byte = pay_byte;
            S_CHK:   tx_byte = chk_q;
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            seq_q      <= 8'h00;
            ovr_q      <= 8'h00;
            chk_q      <= 8'h00;
            idx_q      <= '0;
            timer_q    <= '0;
            rx_ready_q <= 1'b0;
            for (int b = 0; b < PAY_LEN; b++) snap_q[b] <= 8'h00;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            seq_q      <= seq_d;
            ovr_q      <= ovr_d;
            chk_q      <= chk_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            rx_ready_q <= 1'b1;
            for (int b = 0; b < PAY_LEN; b++) snap_q[b] <= snap_d[b];
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: a 4x8 instance with a 100-cycle
// period and a 2x12 instance with a 20-cycle period.
`timescale 1ns/1ps
module tb_telemetry_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ch0;
    logic [23:0] ch1;
    logic        mode [2];
    logic        rxv  [2];
    logic [7:0]  rxb  [2];
    logic        rdy  [2];
    logic        tv   [2];
    logic        tr   [2];
    logic [7:0]  txb  [2];
    logic        bsy  [2];
    logic [7:0]  sq   [2];
    logic [7:0]  ovr  [2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [63:0] frame;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    telemetry_framer #(
        .NUM_CH(4), .CH_WIDTH(8), .PERIOD_CYCLES(100)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ch_data(ch0), .mode(mode[0]),
        .rx_valid(rxv[0]), .rx_byte(rxb[0]), .rx_ready(rdy[0]),
        .tx_valid(tv[0]), .tx_ready(tr[0]), .tx_byte(txb[0]),
        .busy(bsy[0]), .seq(sq[0]), .overrun_count(ovr[0])
    );

    telemetry_framer #(
        .NUM_CH(2), .CH_WIDTH(12), .PERIOD_CYCLES(20)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ch_data(ch1), .mode(mode[1]),
        .rx_valid(rxv[1]), .rx_byte(rxb[1]), .rx_ready(rdy[1]),
        .tx_valid(tv[1]), .tx_ready(tr[1]), .tx_byte(txb[1]),
        .busy(bsy[1]), .seq(sq[1]), .overrun_count(ovr[1])
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_rx(input int d, input logic [7:0] b);
        @(negedge clk);
        rxv[d] = 1'b1;
        rxb[d] = b;
        @(negedge clk);
        rxv[d] = 1'b0;
    endtask

    // Collects one 8-byte frame; with stall set, tx_ready is randomised
    // and every stalled cycle must hold tx_valid and tx_byte.
    task automatic get_frame(input int d, input bit stall);
        int n = 0;
        int k = 0;
        bit held = 1'b0;
        logic [7:0] pb = 8'h00;
        frame = '0;
        while (n < 8 && k < 500) begin
            @(negedge clk);
            k++;
            if (held) check("stall_hold", {tv[d], txb[d]}, {1'b1, pb});
            tr[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tv[d] && tr[d]) begin
                frame = {frame[55:0], txb[d]};
                n++;
            end
            held = tv[d] && !tr[d];
            pb = txb[d];
        end
        check("frame_bytes", 64'(n), 64'd8);
        @(posedge clk);
        #1 tr[d] = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  rx;
        logic [31:0] ch;
        bit          frm;
        bit          stall;
        logic [63:0] exp;
        logic [7:0]  nseq;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int ts [3];
        bit wrapped;
        logic [7:0] ps;

        vt[0] = '{8'h81, 32'h44332211, 1'b0, 1'b0, 64'h0, 8'h00};
        vt[1] = '{8'h82, 32'h44332211, 1'b1, 1'b0, 64'hA504001122334440, 8'h01};
        vt[2] = '{8'h82, 32'h44332211, 1'b1, 1'b1, 64'hA504011122334441, 8'h02};
        vt[3] = '{8'h82, 32'h00000000, 1'b1, 1'b1, 64'hA504020000000006, 8'h03};
        vt[4] = '{8'h82, 32'h80402010, 1'b1, 1'b1, 64'hA5040310204080F7, 8'h04};
        vt[5] = '{8'h82, 32'hFFFFFFFF, 1'b1, 1'b1, 64'hA50404FFFFFFFF00, 8'h05};

        ch0 = '0;
        ch1 = '0;
        for (int d = 0; d < 2; d++) begin
            mode[d] = 1'b1;
            rxv[d] = 1'b0;
            rxb[d] = 8'h00;
            tr[d] = 1'b0;
        end

        #5;
        check("rst_tx_valid", tv[0], 1'b0);
        check("rst_tx_byte", txb[0], 8'h00);
        check("rst_busy", bsy[0], 1'b0);
        check("rst_seq", sq[0], 8'h00);
        check("rst_overrun", ovr[0], 8'h00);
        check("rst_rx_ready", rdy[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rx_ready_up", rdy[0], 1'b1);

        // Request-mode vectors, with and without tx_ready stalls.
        for (int i = 0; i < 6; i++) begin
            ch0 = vt[i].ch;
            send_rx(0, vt[i].rx);
            check($sformatf("v%0d_latency", i), tv[0], vt[i].frm);
            if (vt[i].frm) begin
                get_frame(0, vt[i].stall);
                check($sformatf("v%0d_frame", i), frame, vt[i].exp);
            end else begin
                repeat (10) @(negedge clk);
                check($sformatf("v%0d_idle", i), bsy[0], 1'b0);
            end
            check($sformatf("v%0d_seq", i), sq[0], vt[i].nseq);
        end

        // Snapshot stays frozen after ch_data changes.
        ch0 = 32'hAABBCCDD;
        send_rx(0, 8'h82);
        ch0 = 32'h00000000;
        get_frame(0, 1'b1);
        check("snap_frozen", frame, 64'hA50405DDCCBBAA01);

        // Periodic mode: frames every 100 cycles; mode flip mid-frame.
        @(negedge clk);
        tr[0] = 1'b1;
        mode[0] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            k = 0;
            while (!tv[0] && k < 300) begin
                @(negedge clk);
                k++;
            end
            check("per_start", tv[0], 1'b1);
            ts[f] = cyc;
            @(negedge clk);
            @(negedge clk);
            check("per_seq_byte", txb[0], 8'(8'h06 + f));
            if (f == 2) mode[0] = 1'b1;
            k = 0;
            while (tv[0] && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("per_end", tv[0], 1'b0);
        end
        check("per_gap1", 64'(ts[1] - ts[0]), 64'd100);
        check("per_gap2", 64'(ts[2] - ts[1]), 64'd100);
        check("per_seq", sq[0], 8'h09);
        check("per_overrun", ovr[0], 8'h00);
        repeat (250) @(negedge clk);
        check("per_stopped", bsy[0], 1'b0);
        tr[0] = 1'b0;

        // Three requests while blocked: one pending, one overrun.
        ch0 = 32'h0;
        send_rx(0, 8'h82);
        send_rx(0, 8'h82);
        send_rx(0, 8'h82);
        check("ovr_count", ovr[0], 8'h01);
        check("ovr_busy", bsy[0], 1'b1);
        get_frame(0, 1'b0);
        check("b2b_frame1", frame, 64'hA50409000000000D);
        check("b2b_valid", tv[0], 1'b1);
        get_frame(0, 1'b0);
        check("b2b_frame2", frame, 64'hA5040A000000000E);
        check("b2b_seq", sq[0], 8'h0B);
        check("b2b_ovr", ovr[0], 8'h01);

        // Reset in the middle of the payload.
        ch0 = 32'h44332211;
        send_rx(0, 8'h82);
        tr[0] = 1'b1;
        repeat (5) @(negedge clk);
        tr[0] = 1'b0;
        check("mid_pay_byte2", txb[0], 8'h33);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", tv[0], 1'b0);
        check("mid_rst_busy", bsy[0], 1'b0);
        check("mid_rst_seq", sq[0], 8'h00);
        check("mid_rst_ovr", ovr[0], 8'h00);
        check("mid_rst_rdy", rdy[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_rx(0, 8'h82);
        get_frame(0, 1'b0);
        check("post_rst_frame", frame, 64'hA504001122334440);

        // 2 x 12-bit channels, padded to two bytes each.
        ch1 = {12'hABC, 12'h123};
        send_rx(1, 8'h82);
        get_frame(1, 1'b0);
        check("w12_frame", frame, 64'hA504002301BC0A90);
        check("w12_seq", sq[1], 8'h01);

        // Let the periodic timer run the sequence number through FF->00.
        @(negedge clk);
        mode[1] = 1'b0;
        tr[1] = 1'b1;
        ps = sq[1];
        wrapped = 1'b0;
        k = 0;
        while (!wrapped && k < 6000) begin
            @(negedge clk);
            k++;
            if (sq[1] != ps) begin
                if (ps == 8'hFF) begin
                    wrapped = 1'b1;
                    check("seq_wrap", sq[1], 8'h00);
                end
                ps = sq[1];
            end
        end
        check("seq_wrap_seen", wrapped, 1'b1);
        check("w12_ovr", ovr[1], 8'h00);
        mode[1] = 1'b1;
        tr[1] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
